// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared size encodings, controller FSM states and latency bound
//   LATENCY_MAX  largest supported wait-cycle count
//   size_e       access size encoding (byte/half/word/illegal)
//   state_e      controller FSM states
//   misaligned() flags an illegal size or an offset not aligned to the size
package riscv_mem_pkg;
  localparam int LATENCY_MAX = 7;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    return sz == SZ_ILL || (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/riscv_dmem_lane.sv
// riscv_dmem_lane: byte-lane steering for stores and align/extend for loads
//   i_off      byte offset within the word (addr[1:0])
//   i_size     access size
//   i_unsigned 1 = zero-extend loads, 0 = sign-extend
//   i_wdata    store data, relevant bytes in the low bits
//   i_rword    full storage word being read
//   o_wstrb    byte-lane write enables
//   o_wdata    store data shifted onto its lanes
//   o_rdata    load data shifted to bit 0 and extended
module riscv_dmem_lane import riscv_mem_pkg::*; (
  input  logic [1:0]  i_off,
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [4:0]  w_sh;
  logic [31:0] w_rsh;
  assign w_sh    = {i_off, 3'b000};
  assign o_wdata = i_wdata << w_sh;
  assign w_rsh   = i_rword >> w_sh;
  // halves always occupy lane pair 0/1 or 2/3, selected by offset bit 1
  assign o_wstrb = i_size == SZ_BYTE ? 4'b0001 << i_off :
                   i_size == SZ_HALF ? 4'b0011 << {i_off[1], 1'b0} : 4'b1111;
  assign o_rdata = i_size == SZ_BYTE ? {{24{~i_unsigned & w_rsh[7]}}, w_rsh[7:0]} :
                   i_size == SZ_HALF ? {{16{~i_unsigned & w_rsh[15]}}, w_rsh[15:0]} : w_rsh;
endmodule

// File: rtl/riscv_dmem_ctrl.sv
// riscv_dmem_ctrl: CPU data-memory controller with fixed wait states and byte-lane access
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   req_*        request handshake (valid/ready), write, byte address, size, unsigned, store data
//   resp_valid   one-cycle completion pulse
//   resp_rdata   aligned, extended load data; 0 for stores and errors
//   resp_err     misaligned, out-of-range or illegal-size request
//   stall        pipeline hold, inverse of req_ready
module riscv_dmem_ctrl import riscv_mem_pkg::*; #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);
  localparam int CNT_W = $clog2(LATENCY_MAX + 1);
  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH+1:0] r_addr;
  size_e                 r_size;
  logic                  r_write;
  logic                  r_unsigned;
  logic [31:0]           r_wdata;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [31:0]           r_resp_rdata;
  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic                  w_err;
  logic                  w_access;
  logic [31:0]           w_rword;
  logic [3:0]            w_wstrb;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rdata;
  // any byte-address bit above the word-address range makes the request out of range
  assign w_err      = misaligned(size_e'(req_size), req_addr[1:0]) || (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign w_access   = r_state == S_WAIT && r_cnt == '0;
  assign w_rword    = r_mem[r_addr[ADDR_WIDTH+1:2]];
  assign req_ready  = r_state == S_IDLE;
  assign stall      = ~req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  riscv_dmem_lane u_lane (
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rword    (w_rword),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata)
  );
  // storage is not reset; an async reset forces IDLE so a pending store never reaches here
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (w_access && r_write && w_wstrb[b]) r_mem[r_addr[ADDR_WIDTH+1:2]][8*b +: 8] <= w_wdata[8*b +: 8];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_size       <= SZ_BYTE;
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr       <= req_addr[ADDR_WIDTH+1:0];
          r_size       <= size_e'(req_size);
          r_write      <= req_write;
          r_unsigned   <= req_unsigned;
          r_wdata      <= req_wdata;
          r_state      <= w_err ? S_RESP : S_WAIT;
          r_cnt        <= CNT_W'(LATENCY);
          r_resp_valid <= w_err;
          r_resp_err   <= w_err;
          r_resp_rdata <= '0;
        end
        S_WAIT: if (r_cnt == '0) begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= r_write ? 32'd0 : w_rdata;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= '0;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// tb_riscv_dmem_ctrl: directed self-checking bench for riscv_dmem_ctrl
module tb_riscv_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, resp_rdata;
  logic [1:0]  req_size = 2'b10;
  logic        resp_valid, resp_err, stall;
  logic        b_req_valid = 1'b0, b_req_ready, b_resp_valid, b_resp_err, b_stall;
  logic [31:0] b_resp_rdata;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [8:0]  rdy_v, rv_v, st_v;

  always #5 clk = ~clk;

  riscv_dmem_ctrl #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
  );

  riscv_dmem_ctrl #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(1'b0),
    .req_addr(32'h0), .req_size(2'b10), .req_unsigned(1'b0), .req_wdata(32'h0),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .stall(b_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // one request on u_dut; lat counts cycles from the accepting edge to the response (1 = T+1)
  task automatic xact(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic u,
                      input logic [31:0] wd, output logic [31:0] rdat, output logic err, output int k);
    int   g;
    logic leak;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = 32'hA5A5A5A5;
    k = 1; leak = 1'b0;
    while (!resp_valid && k < 20) begin
      leak |= resp_err | (resp_rdata != 0) | (stall == req_ready);
      @(negedge clk); k++;
    end
    rdat = resp_rdata; err = resp_err;
    chk("quiet_between", {31'd0, leak}, 32'd0);
    @(negedge clk);
    chk("single_pulse", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b1;
    xact(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", lat, 4); chk("sw_rdata", rd, 0); chk("sw_err", {31'd0, er}, 0);
    xact(0, 32'h10, 2'b10, 0, 0, rd, er, lat);
    chk("lw_lat", lat, 4); chk("lw_data", rd, 32'hDEADBEEF); chk("lw_err", {31'd0, er}, 0);
    xact(1, 32'h11, 2'b00, 0, 32'h00000080, rd, er, lat);
    xact(0, 32'h11, 2'b00, 0, 0, rd, er, lat);
    chk("lb_data", rd, 32'hFFFFFF80);
    xact(0, 32'h11, 2'b00, 1, 0, rd, er, lat);
    chk("lbu_data", rd, 32'h00000080);
    xact(0, 32'h10, 2'b10, 0, 0, rd, er, lat);
    chk("lw_after_sb", rd, 32'hDEAD80EF);
    xact(0, 32'h13, 2'b01, 0, 0, rd, er, lat);
    chk("lh_mis_err", {31'd0, er}, 1); chk("lh_mis_lat", lat, 1); chk("lh_mis_rdata", rd, 0);
    xact(1, 32'h13, 2'b01, 0, 32'h1111, rd, er, lat);
    chk("sh_mis_err", {31'd0, er}, 1);
    xact(0, 32'h10, 2'b10, 0, 0, rd, er, lat);
    chk("lw_unchanged", rd, 32'hDEAD80EF);
    xact(0, 32'h1000, 2'b10, 0, 0, rd, er, lat);
    chk("oor_err", {31'd0, er}, 1); chk("oor_lat", lat, 1);
    xact(0, 32'h10, 2'b11, 0, 0, rd, er, lat);
    chk("size11_err", {31'd0, er}, 1);
    xact(0, 32'h12, 2'b10, 0, 0, rd, er, lat);
    chk("lw_mis_err", {31'd0, er}, 1);
    xact(1, 32'h12, 2'b01, 0, 32'hFFFF9A5C, rd, er, lat);
    xact(0, 32'h12, 2'b01, 0, 0, rd, er, lat);
    chk("lh_data", rd, 32'hFFFF9A5C);
    xact(0, 32'h12, 2'b01, 1, 0, rd, er, lat);
    chk("lhu_data", rd, 32'h00009A5C);
    xact(0, 32'h10, 2'b10, 0, 0, rd, er, lat);
    chk("lw_after_sh", rd, 32'h9A5C80EF);
    xact(0, 32'h3FC, 2'b10, 0, 0, rd, er, lat);
    chk("top_word_ok", {31'd0, er}, 0);

    xact(1, 32'h20, 2'b10, 0, 32'h12345678, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_wait", {31'd0, stall}, 1);
    rst = 1'b0;
    #1;
    chk("rst_async_ready", {31'd0, req_ready}, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_resp", {31'd0, resp_valid}, 0);
    end
    rst = 1'b1;
    xact(0, 32'h20, 2'b10, 0, 0, rd, er, lat);
    chk("rst_store_dropped", rd, 32'h12345678);

    @(negedge clk);
    b_req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rdy_v[i] = b_req_ready; rv_v[i] = b_resp_valid; st_v[i] = b_stall;
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    chk("l0_accepts", {23'd0, rdy_v}, 32'b001001001);
    chk("l0_resps", {23'd0, rv_v}, 32'b100100100);
    chk("l0_stall", {23'd0, st_v}, 32'b110110110);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/riscv_dmem_ctrl.md
RISCV_DMEM_CTRL -- requirements
Module: riscv_dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width; storage is 2^ADDR_WIDTH x 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles inserted per access; legal range 0..7.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  CPU presents a request.
REQ-006 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-010 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_wdata  input  32  store data; the relevant bytes are in the low bits.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  32  aligned, extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  valid with resp_valid; misaligned, out-of-range or illegal size.
REQ-015 SHALL have port stall  output  1  equals NOT req_ready; drives the CPU pipeline hold.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 In IDLE, req_ready SHALL be 1, and it SHALL be 0 in WAIT and RESP.
REQ-018 A request SHALL be accepted when req_valid and req_ready are both 1 at a rising edge (cycle T); addr, size, write, unsigned and wdata SHALL be latched at T.
REQ-019 On an error request at T, the FSM SHALL go to RESP and SHALL not access storage; an error is: size 11, half with addr[0]=1, word with addr[1:0]!=0, or any addr bit above ADDR_WIDTH+1 set.
REQ-020 On a legal request at T, the FSM SHALL go to WAIT with the counter loaded to LATENCY; when LATENCY=0, WAIT SHALL last exactly one cycle.
REQ-021 WAIT SHALL decrement the counter each cycle; at counter 0 the access SHALL be performed and the FSM SHALL go to RESP.
REQ-022 resp_valid SHALL be 1 for exactly the single RESP cycle, cycle T+2+LATENCY for legal requests and T+1 for errors; RESP SHALL then go to IDLE.
REQ-023 Maximum throughput SHALL be one request per LATENCY+3 cycles; a request held across busy cycles SHALL be accepted on the first IDLE cycle.
REQ-024 Stores SHALL write only the addressed byte lanes: byte uses lane addr[1:0], half uses lanes addr[1]*2 and addr[1]*2+1, word uses all lanes; other bytes of the word SHALL be preserved.
REQ-025 Loads SHALL shift the addressed lane(s) to bit 0 and then zero- or sign-extend to 32 bits per the latched unsigned flag.
REQ-026 resp_rdata and resp_err SHALL hold their values only during resp_valid and SHALL be 0 otherwise.
REQ-027 Inputs other than req_valid SHALL be ignored while req_ready=0.

Reset
REQ-028 While rst=0, the FSM SHALL be in IDLE, the counter SHALL be 0, and resp_valid, resp_err and resp_rdata SHALL be 0; as a result req_ready=1 and stall=0.
REQ-029 Storage contents SHALL not be reset.
REQ-030 A reset asserted during WAIT SHALL discard the pending store, leaving storage unmodified, and SHALL produce no response.

Structure
REQ-031 The size encodings, the FSM state enum and LATENCY_MAX=7 SHALL reside in the shared package riscv_mem_pkg.
REQ-032 The combinational lane align/extend and write-strobe logic SHALL be a single sub-module, riscv_dmem_lane.

Verification
REQ-033 With LATENCY=2: word store addr 0x10, data 0xDEADBEEF, at T; then word load addr 0x10 -> resp_valid at T+4, and the load returns 0xDEADBEEF with err=0.
REQ-034 Byte store 0x80 to addr 0x11; then lb at 0x11 -> 0xFFFFFF80, lbu at 0x11 -> 0x00000080, lw at 0x10 -> 0xDEAD80EF.
REQ-035 Half load at addr 0x13 -> resp_err=1 and rdata=0 at T+1; storage is unchanged.
REQ-036 Word load at addr 0x00001000 with ADDR_WIDTH=10 -> resp_err=1 at T+1.
REQ-037 req_valid held high continuously for 3 loads with LATENCY=0 -> accepted at T, T+3 and T+6; stall is high for 2 of every 3 cycles.
REQ-038 Word store 0x12345678 to addr 0x20, then rst=0 during WAIT of a subsequent word store 0xFFFFFFFF to addr 0x20; after release, lw at 0x20 -> 0x12345678 and no resp_valid occurs during reset.
